mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_priority_pick.sv | 34 +++
 rtl/mem_req_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory request arbiter: FSM encoding, default
// parameter values and the index-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// First-set search over a request vector rotated by a start pointer; returns the
// winning index in the original (un-rotated) numbering plus a none flag.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W:0]   sum;

  // Doubling the vector turns a rotate into a plain right shift.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    rot_idx = '0;
    none    = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_idx = IDX_W'(i);
        none    = 1'b0;
      end
    end
  end

  assign sum = {1'b0, rot_idx} + {1'b0, ptr};
  assign idx = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : IDX_W'(sum);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one memory port with an IDLE/ISSUE/WAIT FSM.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module mem_req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          mem_valid,
  output logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          mem_ready,
  input  logic                          mem_done,
  output logic                          busy
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t                  state_q;
  logic [IDX_W-1:0]        winner_q;
  logic                    mem_valid_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;

  logic [DATA_WIDTH-1:0]   req_words [NUM_REQ];
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        ptr;
  logic                    pick_none;
  logic                    accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign req_words[gi] = req_data[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .idx  (pick_idx),
    .none (pick_none)
  );

  assign accept = (state_q == ST_IDLE) && !pick_none;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  assign ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign ptr   = ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            winner_q    <= pick_idx;
            mem_data_q  <= req_words[pick_idx];
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem_done) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant is non-zero exactly while a transaction is owned, i.e. while busy.
  assign grant     = busy_q ? (NUM_REQ'(1) << winner_q) : '0;
  assign req_ready = (accept && !rst) ? (NUM_REQ'(1) << pick_idx) : '0;
  assign mem_valid = mem_valid_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            mem_valid;
  logic [DW-1:0]   mem_data;
  logic            mem_ready;
  logic            mem_done;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = idle, 1 = issuing, 2 = waiting for completion.
  int            m_phase;
  int            m_owner;
  int            m_ptr;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .mem_done  (mem_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rv, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_data  = '0;
  endtask

  task automatic step(input logic r, input logic [N-1:0] rv, input logic mr,
                      input logic md, input logic [N*DW-1:0] d);
    int          w;
    logic [63:0] exp_rdy;
    logic [63:0] exp_gnt;
    rst       = r;
    req_valid = rv;
    mem_ready = mr;
    mem_done  = md;
    req_data  = d;
    #2;
    w       = pick(rv, m_ptr);
    exp_rdy = (m_phase == 0 && !r && w >= 0) ? (64'd1 << w) : 64'd0;
    exp_gnt = (m_phase != 0) ? (64'd1 << m_owner) : 64'd0;
    check("req_ready", 64'(req_ready), exp_rdy);
    check("grant",     64'(grant),     exp_gnt);
    check("busy",      64'(busy),      64'(m_phase != 0));
    check("mem_valid", 64'(mem_valid), 64'(m_phase == 1));
    check("mem_data",  64'(mem_data),  64'(m_data));
    if (r) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (w >= 0) begin
          m_owner = w;
          m_data  = d[w*DW +: DW];
          m_phase = 1;
`ifdef ARB_ROUND_ROBIN_EN
          m_ptr   = (w + 1) % N;
`endif
          $display("accept req=%0d data=%h", w, m_data);
        end
        1: if (mr) m_phase = md ? 0 : 2;
        2: if (md) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*DW-1:0] d;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, and req_ready suppressed while reset is high.
    step(1'b1, 4'b1111, 1'b0, 1'b0, rnd_data());
    step(1'b1, 4'b1010, 1'b0, 1'b0, rnd_data());

    // Requesters 1 and 3 pending: requester 1 wins, issue on the next cycle.
    step(1'b0, 4'b1010, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0000, 1'b1, 1'b0, rnd_data());
    step(1'b0, 4'b0000, 1'b0, 1'b1, rnd_data());
    step(1'b0, 4'b0000, 1'b0, 1'b0, rnd_data());

    // Memory stalls five cycles on a known word, then ready+done together.
    d = rnd_data();
    d[DW-1:0] = 32'hDEADBEEF;
    step(1'b0, 4'b0001, 1'b0, 1'b0, d);
    repeat (5) step(1'b0, 4'b1111, 1'b0, 1'b1, rnd_data());
    step(1'b0, 4'b1110, 1'b1, 1'b1, rnd_data());
    step(1'b0, 4'b1110, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0000, 1'b1, 1'b0, rnd_data());
    step(1'b0, 4'b0000, 1'b0, 1'b1, rnd_data());

    // All requesters pending: grant order rotates in round-robin builds.
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    for (int t = 0; t < 5; t++) begin
      step(1'b0, 4'b1111, 1'b0, 1'b0, rnd_data());
      step(1'b0, 4'b1111, 1'b1, 1'b0, rnd_data());
      step(1'b0, 4'b1111, 1'b0, 1'b1, rnd_data());
    end

    // Reset during WAIT after requester 1 was granted; late mem_done ignored.
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0010, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0000, 1'b1, 1'b0, rnd_data());
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0000, 1'b1, 1'b1, rnd_data());
    step(1'b0, 4'b1111, 1'b0, 1'b1, rnd_data());
    step(1'b0, 4'b0000, 1'b1, 1'b1, rnd_data());

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      step(($urandom % 64) == 0, N'($urandom), ($urandom % 3) != 0,
           ($urandom % 3) == 0, rnd_data());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
